cpu_cmd_sequencer: RTL and testbench
====================================

// Module: cpu_cmd_sequencer
// PURPOSE
//  Host-facing command sequencer for the 8-bit register-file/ALU CPU core. Buffers host commands in a small FIFO
//  and replays them on the CPU's ce/load/opcode/data_in/cin pins with correct spacing. Captures data_out/cout after
//  each ALU operation and returns them as a valid/ready result stream. Sits between the host bus and one CPU instance.
// PARAMETERS
//  FIFO_AW   2   log2 of command FIFO depth (default depth 4)
//  CNT_W     16  width of completed-operation counter
// PORTS
//  clk           in   1      system clock, all logic on rising edge
//  rst           in   1      asynchronous reset, active-low (0 = reset)
//  cmd_valid     in   1      host command valid
//  cmd_ready     out  1      FIFO can accept (= !full)
//  cmd_word      in   18     [17]chain [16]load [15:13]sel [12:9]aluop [8:1]data [0]cin
//  res_valid     out  1      ALU result held on res_data/res_cout
//  res_ready     in   1      host consumes result
//  res_data      out  8      captured cpu_data_out
//  res_cout      out  1      captured cpu_cout
//  cpu_ce        out  1      to CPU ce
//  cpu_load      out  1      to CPU load
//  cpu_opcode    out  7      to CPU opcode: {sel, aluop}
//  cpu_data_in   out  8      to CPU data_in
//  cpu_cin       out  1      to CPU cin
//  cpu_data_out  in   8      from CPU data_out (register 0)
//  cpu_cout      in   1      from CPU cout
//  busy          out  1      FSM not IDLE or FIFO not empty
//  ops_done      out  CNT_W  count of captured ALU results
// BEHAVIOUR
//  Reset: FIFO empty, state IDLE, all outputs 0 except cmd_ready=1; carry_reg=0; ops_done=0.
//  Push: cmd_valid && cmd_ready at edge N writes FIFO; entry poppable at N+1. Full: cmd_ready=0, push ignored.
//   Same-cycle push+pop when full is NOT allowed (ready uses full only). Pointers wrap mod 2^FIFO_AW.
//  FSM IDLE: FIFO non-empty and (!res_valid) -> pop head into ISSUE reg, go ISSUE. Empty or res_valid pending -> stay.
//  ISSUE (1 cycle): cpu_ce=1, cpu_load=cmd.load, cpu_opcode={sel,aluop}, cpu_data_in=data, cpu_cin per CONFIGURATION.
//   load=1 -> IDLE next (write done in CPU at this edge). load=0 -> WAIT.
//  WAIT (1 cycle): cpu_ce=0; CPU is in its OPERATION cycle writing register 0 and cout at this edge -> CAPTURE.
//  CAPTURE (1 cycle): res_data<=cpu_data_out, res_cout<=cpu_cout, carry_reg<=cpu_cout, res_valid<=1,
//   ops_done<=ops_done+1 (wraps 2^CNT_W-1 -> 0) -> IDLE.
//  res_valid holds until res_valid && res_ready edge, then clears; res_data/res_cout hold last value.
//  cpu_ce/cpu_load/cpu_opcode/cpu_data_in/cpu_cin are 0 in every state except ISSUE.
//  Latency: load cmd push N -> cpu_ce at N+2. Op cmd push N -> res_valid high from N+5. Back-to-back loads: 1 per 2 cycles.
//  A new command never issues while res_valid=1 (1-deep result buffer; no result dropped).
//  Reset mid-operation: immediate return to reset values; in-flight and queued commands discarded, no result.
//   CPU reset is driven separately; system must reset both together.
// CONFIGURATION
//  SEQ_CARRY_CHAIN_EN defined: op with cmd[17]=1 drives cpu_cin=carry_reg (cout of last captured op);
//   cmd[17]=0 drives cpu_cin=cmd[0]. carry_reg cleared by reset only.
//  Not defined: cmd[17] ignored, cpu_cin=cmd[0] always; carry_reg absent.
// TESTING
//  Load sel=1 data=0x05, load sel=0 data=0x03, op sel=1 aluop=ADD cin=0 -> res_data=0x08, res_cout=0, ops_done=1.
//  Push 5 cmds with res_ready=0 and FIFO_AW=2 -> cmd_ready low after 4th accepted; 5th held until pop.
//  Two ops, res_ready=0 -> first result held, second never issues (cpu_ce stays 0) until res_ready pulse.
//  rst=0 during WAIT of op -> res_valid=0, busy=0, cmd_ready=1, ops_done=0, no cpu_ce after release.
//  SEQ_CARRY_CHAIN_EN: 0xFF+0x01 (cout=1), then chained ADD 0x00+0x00 -> cpu_cin=1, res_data=0x01.
//  CNT_W=4, 16 ops -> ops_done wraps 15 -> 0; res_valid handshake per op correct.

Source files
------------

// File: rtl/cpu_cmd_sequencer_if.sv
// Host-side command/result handshake bundle for cpu_cmd_sequencer.
// master = host, slave = sequencer.
interface cpu_cmd_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [17:0] cmd_word;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;
  logic        res_cout;

  modport master (
    output cmd_valid,
    output cmd_word,
    output res_ready,
    input  cmd_ready,
    input  res_valid,
    input  res_data,
    input  res_cout
  );

  modport slave (
    input  cmd_valid,
    input  cmd_word,
    input  res_ready,
    output cmd_ready,
    output res_valid,
    output res_data,
    output res_cout
  );
endinterface

// File: rtl/cpu_cmd_sequencer.sv
// Host command FIFO + issue FSM for the 8-bit regfile/ALU CPU core.
// Optional macro SEQ_CARRY_CHAIN_EN: chained ops take cin from last cout.
module cpu_cmd_sequencer #(
  parameter int FIFO_AW = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  cpu_cmd_sequencer_if.slave host,
  output logic             cpu_ce,
  output logic             cpu_load,
  output logic [6:0]       cpu_opcode,
  output logic [7:0]       cpu_data_in,
  output logic             cpu_cin,
  input  logic [7:0]       cpu_data_out,
  input  logic             cpu_cout,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_CAPT  = 2'd3;

  logic [1:0]       r_state;
  logic [17:0]      r_mem [DEPTH];
  logic [FIFO_AW:0] r_wptr;
  logic [FIFO_AW:0] r_rptr;
  logic [17:0]      r_issue;
  logic             r_res_valid;
  logic [7:0]       r_res_data;
  logic             r_res_cout;
  logic [CNT_W-1:0] r_ops;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_is_issue;
  logic w_cin;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                   (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
  assign w_push  = host.cmd_valid && !w_full;
  // 1-deep result buffer: hold off issue while a result is unread
  assign w_pop   = (r_state == S_IDLE) && !w_empty && !r_res_valid;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[FIFO_AW-1:0]] <= host.cmd_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_issue <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_issue <= r_mem[r_rptr[FIFO_AW-1:0]];
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= r_issue[16] ? S_IDLE : S_WAIT;
        S_WAIT:  r_state <= S_CAPT;
        S_CAPT:  r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_cout  <= 1'b0;
      r_ops       <= '0;
    end else if (r_state == S_CAPT) begin
      r_res_valid <= 1'b1;
      r_res_data  <= cpu_data_out;
      r_res_cout  <= cpu_cout;
      r_ops       <= r_ops + 1'b1;
    end else if (r_res_valid && host.res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

`ifdef SEQ_CARRY_CHAIN_EN
  logic r_carry;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_carry <= 1'b0;
    end else if (r_state == S_CAPT) begin
      r_carry <= cpu_cout;
    end
  end

  assign w_cin = (r_issue[17] && !r_issue[16]) ? r_carry : r_issue[0];
`else
  logic w_unused_chain;

  assign w_unused_chain = r_issue[17];
  assign w_cin          = r_issue[0];
`endif

  assign w_is_issue = (r_state == S_ISSUE);

  assign cpu_ce      = w_is_issue;
  assign cpu_load    = w_is_issue && r_issue[16];
  assign cpu_opcode  = w_is_issue ? r_issue[15:9] : 7'd0;
  assign cpu_data_in = w_is_issue ? r_issue[8:1] : 8'd0;
  assign cpu_cin     = w_is_issue && w_cin;

  assign host.cmd_ready = !w_full;
  assign host.res_valid = r_res_valid;
  assign host.res_data  = r_res_data;
  assign host.res_cout  = r_res_cout;

  assign busy     = (r_state != S_IDLE) || !w_empty;
  assign ops_done = r_ops;

endmodule

// File: tb/tb_cpu_cmd_sequencer.sv
// Directed bench for cpu_cmd_sequencer with a small behavioural CPU.
// CPU model: load writes reg[sel]; op 0 = ADD into r0, op 1 = AND.
`timescale 1ns/1ps
module tb_cpu_cmd_sequencer;

`ifdef SEQ_CARRY_CHAIN_EN
  localparam int EXP_CIN = 1;
`else
  localparam int EXP_CIN = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cpu_cmd_sequencer_if h ();

  logic       cpu_ce;
  logic       cpu_load;
  logic [6:0] cpu_opcode;
  logic [7:0] cpu_data_in;
  logic       cpu_cin;
  logic [7:0] cpu_data_out;
  logic       cpu_cout;
  logic       busy;
  logic [3:0] ops_done;

  cpu_cmd_sequencer #(.FIFO_AW(2), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .host         (h),
    .cpu_ce       (cpu_ce),
    .cpu_load     (cpu_load),
    .cpu_opcode   (cpu_opcode),
    .cpu_data_in  (cpu_data_in),
    .cpu_cin      (cpu_cin),
    .cpu_data_out (cpu_data_out),
    .cpu_cout     (cpu_cout),
    .busy         (busy),
    .ops_done     (ops_done)
  );

  logic [7:0] regs [8];
  logic       pend;
  logic [2:0] p_sel;
  logic [3:0] p_op;
  logic       p_cin;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= 8'd0;
      pend     <= 1'b0;
      p_sel    <= 3'd0;
      p_op     <= 4'd0;
      p_cin    <= 1'b0;
      cpu_cout <= 1'b0;
    end else begin
      pend <= cpu_ce && !cpu_load;
      if (cpu_ce) begin
        p_sel <= cpu_opcode[6:4];
        p_op  <= cpu_opcode[3:0];
        p_cin <= cpu_cin;
      end
      if (cpu_ce && cpu_load) regs[cpu_opcode[6:4]] <= cpu_data_in;
      if (pend) begin
        if (p_op == 4'd1) begin
          regs[0]  <= regs[0] & regs[p_sel];
          cpu_cout <= 1'b0;
        end else begin
          {cpu_cout, regs[0]} <= {1'b0, regs[0]} + {1'b0, regs[p_sel]}
                                 + {8'd0, p_cin};
        end
      end
    end
  end

  assign cpu_data_out = regs[0];

  int n_run  = 0;
  int n_fail = 0;

  function automatic logic [17:0] mk(logic ch, logic ld, logic [2:0] sel,
                                     logic [3:0] op, logic [7:0] d,
                                     logic ci);
    return {ch, ld, sel, op, d, ci};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(logic [17:0] w);
    int k;
    k = 0;
    while (!h.cmd_ready && k < 50) begin
      tick();
      k++;
    end
    if (!h.cmd_ready) chk("push_timeout", 32'(h.cmd_ready), 1);
    h.cmd_word  = w;
    h.cmd_valid = 1'b1;
    tick();
    h.cmd_valid = 1'b0;
  endtask

  task automatic wait_res();
    int k;
    k = 0;
    while (!h.res_valid && k < 50) begin
      tick();
      k++;
    end
    chk("res_wait", 32'(h.res_valid), 1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 50) begin
      tick();
      k++;
    end
    chk("idle_wait", 32'(busy), 0);
  endtask

  task automatic consume();
    h.res_ready = 1'b1;
    tick();
    h.res_ready = 1'b0;
  endtask

  logic [7:0] exp_r0;
  logic       ce_seen;

  initial begin
    h.cmd_valid = 1'b0;
    h.cmd_word  = '0;
    h.res_ready = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_cmd_ready", 32'(h.cmd_ready), 1);
    chk("rst_res_valid", 32'(h.res_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ops", 32'(ops_done), 0);
    chk("rst_ce", 32'(cpu_ce), 0);
    chk("rst_res_data", 32'(h.res_data), 0);
    rst = 1'b1;
    tick();

    // load r1 = 5: cpu_ce two edges after push
    push(mk(1'b0, 1'b1, 3'd1, 4'd0, 8'h05, 1'b0));
    chk("ld_busy", 32'(busy), 1);
    chk("ld_ce_early", 32'(cpu_ce), 0);
    tick();
    chk("ld_ce", 32'(cpu_ce), 1);
    chk("ld_load", 32'(cpu_load), 1);
    chk("ld_opcode", 32'(cpu_opcode), 32'h10);
    chk("ld_data_in", 32'(cpu_data_in), 32'h05);
    tick();
    chk("ld_ce_off", 32'(cpu_ce), 0);

    push(mk(1'b0, 1'b1, 3'd0, 4'd0, 8'h03, 1'b0));
    wait_idle();

    // r0 = 3 + 5 with res_valid latency check
    push(mk(1'b0, 1'b0, 3'd1, 4'd0, 8'h00, 1'b0));
    repeat (3) tick();
    chk("op_lat_early", 32'(h.res_valid), 0);
    tick();
    chk("op_lat", 32'(h.res_valid), 1);
    chk("add_data", 32'(h.res_data), 32'h08);
    chk("add_cout", 32'(h.res_cout), 0);
    chk("add_ops", 32'(ops_done), 1);
    consume();
    chk("res_clr", 32'(h.res_valid), 0);

    // r0 = 8 + 5 + 1, left unread to stall the FIFO
    push(mk(1'b0, 1'b0, 3'd1, 4'd0, 8'h00, 1'b1));
    wait_res();
    chk("cin_data", 32'(h.res_data), 32'h0E);
    chk("cin_ops", 32'(ops_done), 2);
    push(mk(1'b0, 1'b1, 3'd2, 4'd0, 8'h10, 1'b0));
    push(mk(1'b0, 1'b1, 3'd3, 4'd0, 8'h20, 1'b0));
    push(mk(1'b0, 1'b1, 3'd4, 4'd0, 8'h30, 1'b0));
    push(mk(1'b0, 1'b1, 3'd5, 4'd0, 8'h40, 1'b0));
    chk("full_ready", 32'(h.cmd_ready), 0);
    chk("full_no_ce", 32'(cpu_ce), 0);
    h.cmd_word  = mk(1'b0, 1'b1, 3'd6, 4'd0, 8'h50, 1'b0);
    h.cmd_valid = 1'b1;
    repeat (2) tick();
    chk("full_hold", 32'(h.cmd_ready), 0);
    chk("full_res_held", 32'(h.res_valid), 1);
    h.res_ready = 1'b1;
    tick();
    h.res_ready = 1'b0;
    chk("full_res_clr", 32'(h.res_valid), 0);
    tick();
    chk("ready_after_pop", 32'(h.cmd_ready), 1);
    tick();
    h.cmd_valid = 1'b0;
    chk("full_again", 32'(h.cmd_ready), 0);

    push(mk(1'b0, 1'b0, 3'd6, 4'd0, 8'h00, 1'b0));
    wait_res();
    chk("fifo_order_data", 32'(h.res_data), 32'h5E);
    chk("fifo_order_ops", 32'(ops_done), 3);
    consume();

    // two ops with res_ready low: the second must not issue
    push(mk(1'b0, 1'b0, 3'd2, 4'd0, 8'h00, 1'b0));
    push(mk(1'b0, 1'b0, 3'd3, 4'd0, 8'h00, 1'b0));
    wait_res();
    chk("two_first", 32'(h.res_data), 32'h6E);
    ce_seen = 1'b0;
    repeat (6) begin
      tick();
      if (cpu_ce) ce_seen = 1'b1;
    end
    chk("two_no_issue", 32'(ce_seen), 0);
    chk("two_held", 32'(h.res_data), 32'h6E);
    consume();
    wait_res();
    chk("two_second", 32'(h.res_data), 32'h8E);
    chk("two_ops", 32'(ops_done), 5);
    consume();

    // 0x01 + 0xFF overflows
    push(mk(1'b0, 1'b1, 3'd7, 4'd0, 8'hFF, 1'b0));
    push(mk(1'b0, 1'b1, 3'd0, 4'd0, 8'h01, 1'b0));
    push(mk(1'b0, 1'b0, 3'd7, 4'd0, 8'h00, 1'b0));
    wait_res();
    chk("ovf_data", 32'(h.res_data), 32'h00);
    chk("ovf_cout", 32'(h.res_cout), 1);
    chk("ovf_ops", 32'(ops_done), 6);
    consume();

    // chained ADD 0x00 + 0x00 with cmd cin = 0
    push(mk(1'b0, 1'b1, 3'd7, 4'd0, 8'h00, 1'b0));
    wait_idle();
    push(mk(1'b1, 1'b0, 3'd7, 4'd0, 8'h00, 1'b0));
    tick();
    chk("chain_ce", 32'(cpu_ce), 1);
    chk("chain_cin", 32'(cpu_cin), EXP_CIN);
    wait_res();
    chk("chain_data", 32'(h.res_data), EXP_CIN);
    chk("chain_ops", 32'(ops_done), 7);
    consume();

    // counter wrap: ops 8..16 with r0 += 5 each
    exp_r0 = 8'(EXP_CIN);
    for (int i = 0; i < 9; i++) begin
      push(mk(1'b0, 1'b0, 3'd1, 4'd0, 8'h00, 1'b0));
      wait_res();
      exp_r0 = exp_r0 + 8'd5;
      chk("wrap_data", 32'(h.res_data), 32'(exp_r0));
      chk("wrap_ops", 32'(ops_done), (8 + i) % 16);
      consume();
      chk("wrap_res_clr", 32'(h.res_valid), 0);
    end

    push(mk(1'b0, 1'b0, 3'd1, 4'd0, 8'h00, 1'b0));
    wait_res();
    chk("pre_rst_ops", 32'(ops_done), 1);
    consume();

    // reset during WAIT with a load still queued
    push(mk(1'b0, 1'b0, 3'd1, 4'd0, 8'h00, 1'b0));
    push(mk(1'b0, 1'b1, 3'd2, 4'd0, 8'h77, 1'b0));
    chk("mid_issue_ce", 32'(cpu_ce), 1);
    chk("mid_issue_load", 32'(cpu_load), 0);
    tick();
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_res_valid", 32'(h.res_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(h.cmd_ready), 1);
    chk("mid_rst_ops", 32'(ops_done), 0);
    tick();
    rst = 1'b1;
    ce_seen = 1'b0;
    repeat (8) begin
      tick();
      if (cpu_ce) ce_seen = 1'b1;
    end
    chk("post_rst_no_ce", 32'(ce_seen), 0);
    chk("post_rst_res", 32'(h.res_valid), 0);
    chk("post_rst_busy", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
